// File: rtl/wb_pkg.sv
// Shared types for the writeback buffer: stored entry layout and FSM state encoding.
// DATA_WIDTH falls back to a 64-bit line when the cache parameter header is not in the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package wb_pkg;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = `DATA_WIDTH;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } wb_state_t;
endpackage

// File: rtl/wb_fifo_ctrl.sv
// Pointer, occupancy and full/overflow bookkeeping for the writeback buffer.
module wb_fifo_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push,
    output logic             pop,
    output logic             drop,
    output logic             full,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);
    assign full = (count == CNT_W'(DEPTH));
    assign pop  = pop_req && (count != '0);
    // A simultaneous pop frees the slot, so a full buffer can still take a push.
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/writeback_buffer.sv
// Dirty-victim writeback buffer: FIFO of evicted lines drained to memory, with flush handshake.
// Optional WB_FORWARD_EN builds a youngest-match lookup over pending victims.
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  repl_valid,
    input  logic                  repl_dirty,
    input  logic [ADDR_WIDTH-1:0] repl_addr,
    input  logic [DATA_WIDTH-1:0] Data_repl,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  full,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  ovf_err,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             push, pop, drop;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    wb_state_t        state_q, state_d;

    // Entries are held at package widths; module widths must not exceed them.
    wb_entry_t mem [DEPTH];

    wb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk      (clk),
        .RST      (RST),
        .push_req (repl_valid && repl_dirty),
        .pop_req  (wb_ready),
        .push     (push),
        .pop      (pop),
        .drop     (drop),
        .full     (full),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: WB_ADDR_W'(repl_addr), data: WB_DATA_W'(Data_repl)};
    end

    assign wb_valid = (count != '0);
    assign wb_addr  = ADDR_WIDTH'(mem[rd_ptr].addr);
    assign wb_data  = DATA_WIDTH'(mem[rd_ptr].data);

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            ovf_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (drop) ovf_err <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req)          state_d = FLUSH;
                else if (count != '0)   state_d = DRAIN;
            end
            DRAIN: begin
                if (flush_req)          state_d = FLUSH;
                else if (count == '0)   state_d = IDLE;
            end
            FLUSH: begin
                // Further flush requests are absorbed; completion is the first empty cycle.
                if (count == '0) begin
                    flush_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem[slot].addr == WB_ADDR_W'(lookup_addr))) begin
                lookup_hit  = 1'b1;
                lookup_data = DATA_WIDTH'(mem[slot].data);
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_addr;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif
endmodule

// File: tb/tb_writeback_buffer.sv
// Randomized and directed bench for writeback_buffer against a queue-based reference model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module tb_writeback_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = `DATA_WIDTH;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          RST;
    logic          repl_valid, repl_dirty, wb_ready, flush_req;
    logic [AW-1:0] repl_addr, lookup_addr, wb_addr;
    logic [DW-1:0] Data_repl, wb_data, lookup_data;
    logic          wb_valid, full, flush_done, ovf_err, lookup_hit;

    always #5 clk = ~clk;

    writeback_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .RST(RST),
        .repl_valid(repl_valid), .repl_dirty(repl_dirty), .repl_addr(repl_addr), .Data_repl(Data_repl),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .full(full), .flush_req(flush_req), .flush_done(flush_done), .ovf_err(ovf_err),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_ovf, m_flushing;
    int   passed = 0, total = 0;

    function automatic bit m_done();
        return m_flushing && (q.size() == 0);
    endfunction

    function automatic void m_lookup(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (q[i]) if (FWD && q[i].a == a) begin hit = 1'b1; d = q[i].d; end
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom, $urandom});
    endfunction

    task automatic quiet();
        repl_valid = 0; repl_dirty = 0; repl_addr = '0; Data_repl = '0;
        wb_ready = 0; flush_req = 0; lookup_addr = '0;
    endtask

    // Advance the model by the current inputs, then clock the DUT.
    task automatic tick();
        bit pop, att, acc, done;
        ent_t e;
        done = m_done();
        pop  = (q.size() != 0) && wb_ready;
        att  = repl_valid && repl_dirty;
        acc  = att && ((q.size() < DEPTH) || pop);
        if (RST) begin
            q.delete(); m_ovf = 0; m_flushing = 0;
        end else begin
            if (att && !acc) m_ovf = 1;
            if (pop) void'(q.pop_front());
            if (acc) begin e.a = repl_addr; e.d = Data_repl; q.push_back(e); end
            if (done) m_flushing = 0;
            else if (flush_req) m_flushing = 1;
        end
        @(posedge clk); #1;
        flush_req = 0;
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        repl_valid = 1; repl_dirty = 1; repl_addr = a; Data_repl = d;
        tick();
        repl_valid = 0; repl_dirty = 0;
    endtask

    task automatic do_reset();
        RST = 1; tick(); RST = 0;
    endtask

    task automatic test_reset();
        quiet();
        do_reset();
        total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b exp 0", wb_valid); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
        total++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf_err); else passed++;
        total++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done got %b exp 0", flush_done); else passed++;
    endtask

    task automatic test_hold_stable();
        logic [DW-1:0] d0;
        d0 = rnd_data();
        push_one(32'h100, d0);
        push_one(32'h200, rnd_data());
        push_one(32'h300, rnd_data());
        total++; if (int'(dut.count) !== 3) $display("FAIL hold_count got %0d exp 3", dut.count); else passed++;
        for (int c = 0; c < 10; c++) begin
            total++; if (wb_valid !== 1'b1) $display("FAIL hold_valid cyc %0d got %b exp 1", c, wb_valid); else passed++;
            total++; if (wb_addr !== 32'h100) $display("FAIL hold_addr cyc %0d got %h exp 100", c, wb_addr); else passed++;
            total++; if (wb_data !== d0) $display("FAIL hold_data cyc %0d got %h exp %h", c, wb_data, d0); else passed++;
            tick();
        end
        wb_ready = 1;
        for (int c = 0; c < 3; c++) begin
            total++; if (wb_addr !== q[0].a) $display("FAIL drain_order beat %0d got %h exp %h", c, wb_addr, q[0].a); else passed++;
            tick();
        end
        total++; if (wb_valid !== 1'b0) $display("FAIL drain_empty got %b exp 0", wb_valid); else passed++;
        wb_ready = 0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) push_one(AW'(32'h1000 + 32'h40 * i), rnd_data());
        total++; if (full !== 1'b1) $display("FAIL ovf_full got %b exp 1", full); else passed++;
        push_one(32'hDEAD0, rnd_data());
        total++; if (ovf_err !== 1'b1) $display("FAIL ovf_set got %b exp 1", ovf_err); else passed++;
        total++; if (int'(dut.count) !== DEPTH) $display("FAIL ovf_count got %0d exp %0d", dut.count, DEPTH); else passed++;
        total++; if (wb_addr !== q[0].a) $display("FAIL ovf_head got %h exp %h", wb_addr, q[0].a); else passed++;
        wb_ready = 1;
        push_one(32'hBEEF0, rnd_data());
        wb_ready = 0;
        total++; if (int'(dut.count) !== DEPTH) $display("FAIL ovf_pushpop_count got %0d exp %0d", dut.count, DEPTH); else passed++;
        total++; if (full !== 1'b1) $display("FAIL ovf_pushpop_full got %b exp 1", full); else passed++;
        wb_ready = 1;
        for (int c = 0; c < DEPTH; c++) begin
            total++; if (wb_addr !== q[0].a || wb_data !== q[0].d) $display("FAIL ovf_drain beat %0d got %h exp %h", c, wb_addr, q[0].a); else passed++;
            tick();
        end
        wb_ready = 0;
        total++; if (ovf_err !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf_err); else passed++;
        do_reset();
        total++; if (ovf_err !== 1'b0) $display("FAIL ovf_cleared got %b exp 0", ovf_err); else passed++;
    endtask

    task automatic test_clean_drop();
        repl_valid = 1; repl_dirty = 0; repl_addr = 32'h500; Data_repl = rnd_data();
        tick();
        repl_valid = 0;
        total++; if (wb_valid !== 1'b0) $display("FAIL clean_valid got %b exp 0", wb_valid); else passed++;
        total++; if (int'(dut.count) !== 0) $display("FAIL clean_count got %0d exp 0", dut.count); else passed++;
    endtask

    task automatic test_flush();
        int pulses, beats;
        logic [AW-1:0] exp_a [2];
        push_one(32'hA00, rnd_data());
        push_one(32'hB00, rnd_data());
        exp_a[0] = 32'hA00; exp_a[1] = 32'hB00;
        pulses = 0; beats = 0;
        flush_req = 1; wb_ready = 1;
        for (int c = 0; c < 8; c++) begin
            total++; if (flush_done !== m_done()) $display("FAIL flush_done cyc %0d got %b exp %b", c, flush_done, m_done()); else passed++;
            if (flush_done) pulses++;
            if (wb_valid && beats < 2) begin
                total++; if (wb_addr !== exp_a[beats]) $display("FAIL flush_beat %0d got %h exp %h", beats, wb_addr, exp_a[beats]); else passed++;
                beats++;
            end
            tick();
        end
        wb_ready = 0;
        total++; if (pulses !== 1) $display("FAIL flush_pulses got %0d exp 1", pulses); else passed++;
        total++; if (beats !== 2) $display("FAIL flush_beats got %0d exp 2", beats); else passed++;
        flush_req = 1;
        tick();
        total++; if (flush_done !== 1'b1) $display("FAIL flush_empty got %b exp 1", flush_done); else passed++;
        tick();
        total++; if (flush_done !== 1'b0) $display("FAIL flush_empty_once got %b exp 0", flush_done); else passed++;
    endtask

    task automatic test_forward();
        bit eh; logic [DW-1:0] ed, db;
        db = rnd_data();
        push_one(32'h40, rnd_data());
        push_one(32'h40, db);
        lookup_addr = 32'h40; #1;
        m_lookup(lookup_addr, eh, ed);
        total++; if (lookup_hit !== eh) $display("FAIL fwd_hit got %b exp %b", lookup_hit, eh); else passed++;
        total++; if (lookup_data !== ed) $display("FAIL fwd_data got %h exp %h", lookup_data, ed); else passed++;
        lookup_addr = 32'h80;
        repl_valid = 1; repl_dirty = 1; repl_addr = 32'h80; Data_repl = rnd_data(); #1;
        m_lookup(lookup_addr, eh, ed);
        total++; if (lookup_hit !== eh) $display("FAIL fwd_same_cycle got %b exp %b", lookup_hit, eh); else passed++;
        tick();
        repl_valid = 0; repl_dirty = 0; #1;
        m_lookup(lookup_addr, eh, ed);
        total++; if (lookup_hit !== eh || lookup_data !== ed) $display("FAIL fwd_next_cycle got %b/%h exp %b/%h", lookup_hit, lookup_data, eh, ed); else passed++;
        do_reset();
    endtask

    task automatic test_reset_mid_drain();
        push_one(32'hC00, rnd_data());
        push_one(32'hD00, rnd_data());
        tick();
        RST = 1; tick(); RST = 0;
        total++; if (wb_valid !== 1'b0) $display("FAIL rst_drain_valid got %b exp 0", wb_valid); else passed++;
        total++; if (int'(dut.count) !== 0) $display("FAIL rst_drain_count got %0d exp 0", dut.count); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL rst_drain_state got %0d exp %0d", dut.state_q, IDLE); else passed++;
        wb_ready = 1;
        for (int c = 0; c < 3; c++) begin
            total++; if (wb_valid !== 1'b0) $display("FAIL rst_drain_quiet cyc %0d got %b exp 0", c, wb_valid); else passed++;
            tick();
        end
        wb_ready = 0;
    endtask

    task automatic test_random();
        bit eh; logic [DW-1:0] ed;
        for (int c = 0; c < 400; c++) begin
            repl_valid  = ($urandom_range(0, 1) == 1);
            repl_dirty  = ($urandom_range(0, 3) != 0);
            repl_addr   = AW'(32'h40 * $urandom_range(1, 4));
            Data_repl   = rnd_data();
            wb_ready    = ($urandom_range(0, 2) == 0);
            flush_req   = ($urandom_range(0, 15) == 0);
            lookup_addr = AW'(32'h40 * $urandom_range(1, 4));
            #1;
            m_lookup(lookup_addr, eh, ed);
            total++; if (wb_valid !== (q.size() != 0)) $display("FAIL rnd_valid cyc %0d got %b exp %b", c, wb_valid, q.size() != 0); else passed++;
            if (q.size() != 0) begin
                total++; if (wb_addr !== q[0].a || wb_data !== q[0].d) $display("FAIL rnd_head cyc %0d got %h/%h exp %h/%h", c, wb_addr, wb_data, q[0].a, q[0].d); else passed++;
            end
            total++; if (full !== (q.size() == DEPTH)) $display("FAIL rnd_full cyc %0d got %b exp %b", c, full, q.size() == DEPTH); else passed++;
            total++; if (ovf_err !== m_ovf) $display("FAIL rnd_ovf cyc %0d got %b exp %b", c, ovf_err, m_ovf); else passed++;
            total++; if (flush_done !== m_done()) $display("FAIL rnd_flush_done cyc %0d got %b exp %b", c, flush_done, m_done()); else passed++;
            total++; if (lookup_hit !== eh || lookup_data !== ed) $display("FAIL rnd_lookup cyc %0d got %b/%h exp %b/%h", c, lookup_hit, lookup_data, eh, ed); else passed++;
            tick();
        end
        quiet();
    endtask

    initial begin
        RST = 1;
        quiet();
        m_ovf = 0; m_flushing = 0;
        test_reset();
        test_hold_stable();
        test_overflow();
        test_clean_drop();
        test_flush();
        test_forward();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
